data_mem_responder: RTL and testbench

//  Handshaked, multi-cycle data-memory responder: target side of the processor's

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Handshaked doubleword data-memory responder: accepts one load/store at a time
// and returns its response a fixed number of cycles after acceptance.
module data_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on the rising CLK edge where req_valid and
    // req_ready are both high; a response transfers on the edge where resp_valid
    // and resp_ready are both high. Neither ready depends combinationally on the
    // matching valid, and a valid/payload once raised stays stable until taken.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [7:0]  mem_q [2**ADDR_BITS];

    logic                 accept;
    logic                 req_error;
    logic                 wr_en;
    logic [ADDR_BITS-4:0] dw_idx;
    logic [63:0]          rd_word;

    assign dw_idx    = req_addr[ADDR_BITS-1:3];
    assign req_error = (req_addr[2:0] != 3'd0) | (req_addr[63:ADDR_BITS] != '0);

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign dbg_state  = state_q;

    // Reset takes priority over a simultaneous request, including its store.
    assign accept = req_valid & req_ready & ~reset;
    assign wr_en  = accept & req_write & ~req_error;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) begin
            rd_word[8*k +: 8] = mem_q[{dw_idx, 3'(k)}];
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = LAT_CNT;
                    rdata_d = (req_write | req_error) ? 64'd0 : rd_word;
                    error_d = req_error;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Counter is frozen here; payload holds until the requester takes it.
                if (resp_ready) begin
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Storage survives reset; a store commits at its acceptance edge.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[{dw_idx, 3'(k)}] <= req_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (latency 2, 1, 4),
// scoreboard queue of expected {error, rdata} responses and an address model.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        rv    [3];
    logic        rr    [3];
    logic        rw    [3];
    logic [63:0] ra    [3];
    logic [63:0] rwd   [3];
    logic        vld   [3];
    logic        prdy  [3];
    logic [63:0] rdata [3];
    logic        rerr  [3];
    logic [1:0]  dbg   [3];

    int lat_of [3] = '{2, 1, 4};

    logic [64:0] exp_q [$];
    logic [63:0] model [logic [63:0]];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_BITS(10),
            .LATENCY  (g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .CLK       (clk),
            .reset     (reset),
            .req_valid (rv[g]),
            .req_ready (rr[g]),
            .req_write (rw[g]),
            .req_addr  (ra[g]),
            .req_wdata (rwd[g]),
            .resp_valid(vld[g]),
            .resp_ready(prdy[g]),
            .resp_rdata(rdata[g]),
            .resp_error(rerr[g]),
            .dbg_state (dbg[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: compute the response and update the address model.
    task automatic push_exp(input logic w, input logic [63:0] a, input logic [63:0] d);
        logic err;
        err = (a[2:0] != 3'd0) || (a[63:10] != 54'd0);
        if (err) begin
            exp_q.push_back({1'b1, 64'd0});
        end else if (w) begin
            model[a] = d;
            exp_q.push_back({1'b0, 64'd0});
        end else begin
            exp_q.push_back({1'b0, model.exists(a) ? model[a] : 64'd0});
        end
    endtask

    task automatic send_req(input int i, input logic w, input logic [63:0] a, input logic [63:0] d);
        int n;
        rv[i]  = 1'b1;
        rw[i]  = w;
        ra[i]  = a;
        rwd[i] = d;
        n = 0;
        while (!rr[i] && n < 50) begin
            tick();
            n++;
        end
        if (!rr[i]) check($sformatf("req_timeout%0d", i), 64'(rr[i]), 64'd1);
        tick();
        rv[i] = 1'b0;
    endtask

    task automatic take_resp(input int i, input int delay, output logic [63:0] obs);
        logic [64:0] e;
        for (int k = 0; k < delay; k++) begin
            tick();
            check($sformatf("hold_valid%0d", i), 64'(vld[i]), 64'd1);
        end
        obs = rdata[i];
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_dead_beef_dead_beef;
        check($sformatf("rdata%0d", i), rdata[i], e[63:0]);
        check($sformatf("error%0d", i), 64'(rerr[i]), 64'(e[64]));
        prdy[i] = 1'b1;
        tick();
        prdy[i] = 1'b0;
        check($sformatf("valid_drop%0d", i), 64'(vld[i]), 64'd0);
        check($sformatf("ready_back%0d", i), 64'(rr[i]), 64'd1);
    endtask

    // Called just after the acceptance edge.
    task automatic finish_txn(input int i, input int delay, output logic [63:0] obs);
        int n;
        check($sformatf("ready_low%0d", i), 64'(rr[i]), 64'd0);
        n = 0;
        while (!vld[i] && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("latency%0d", i), 64'(n), 64'(lat_of[i]));
        check($sformatf("ready_in_resp%0d", i), 64'(rr[i]), 64'd0);
        take_resp(i, delay, obs);
    endtask

    task automatic do_txn(input int i, input logic w, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] obs);
        push_exp(w, a, d);
        send_req(i, w, a, d);
        finish_txn(i, 0, obs);
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] held;
        logic [63:0] a;
        logic [63:0] d;
        logic        w;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0; prdy[i] = 1'b0;
        end

        // Reset with a request present: nothing accepted.
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h30; rwd[0] = 64'hDEAD_DEAD_DEAD_DEAD;
        repeat (2) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_ready%0d", i), 64'(rr[i]), 64'd1);
                check($sformatf("rst_valid%0d", i), 64'(vld[i]), 64'd0);
                check($sformatf("rst_state%0d", i), 64'(dbg[i]), 64'd0);
            end
        end
        check("rst_rdata", rdata[0], 64'd0);
        check("rst_error", 64'(rerr[0]), 64'd0);
        reset = 1'b0; rv[0] = 1'b0;
        tick();

        // Store then load, little-endian low byte.
        do_txn(0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, obs);
        do_txn(0, 1'b0, 64'h10, 64'h0, obs);
        check("load_word", obs, 64'h0123_4567_89AB_CDEF);
        check("load_byte0", 64'(obs[7:0]), 64'hEF);

        // Reset with a store present must not write.
        do_txn(0, 1'b1, 64'h30, 64'h1111_2222_3333_4444, obs);
        reset = 1'b1;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h30; rwd[0] = 64'hDEAD_DEAD_DEAD_DEAD;
        repeat (2) begin
            tick();
            check("rst2_ready", 64'(rr[0]), 64'd1);
            check("rst2_valid", 64'(vld[0]), 64'd0);
        end
        reset = 1'b0; rv[0] = 1'b0;
        tick();
        do_txn(0, 1'b0, 64'h30, 64'h0, obs);
        check("rst_no_write", obs, 64'h1111_2222_3333_4444);

        // Latency 1 and 4 instances.
        do_txn(1, 1'b1, 64'h3C0, 64'hCAFE_F00D_1234_5678, obs);
        do_txn(1, 1'b0, 64'h3C0, 64'h0, obs);
        do_txn(2, 1'b1, 64'h3C8, 64'h8765_4321_0FED_CBA9, obs);
        do_txn(2, 1'b0, 64'h3C8, 64'h0, obs);

        // Backpressure with a competing request held on the port.
        push_exp(1'b0, 64'h10, 64'h0);
        send_req(0, 1'b0, 64'h10, 64'h0);
        check("bp_ready_low", 64'(rr[0]), 64'd0);
        while (!vld[0]) tick();
        held = rdata[0];
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h48; rwd[0] = 64'h5A5A_5A5A_0F0F_0F0F;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 64'(vld[0]), 64'd1);
            check("bp_rdata", rdata[0], held);
            check("bp_ready", 64'(rr[0]), 64'd0);
        end
        take_resp(0, 0, obs);
        check("bp_no_same_cycle", 64'(dbg[0]), 64'd0);
        push_exp(1'b1, 64'h48, 64'h5A5A_5A5A_0F0F_0F0F);
        tick();
        rv[0] = 1'b0;
        finish_txn(0, 0, obs);
        do_txn(0, 1'b0, 64'h48, 64'h0, obs);
        check("bp_store_data", obs, 64'h5A5A_5A5A_0F0F_0F0F);

        // Error cases.
        do_txn(0, 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, obs);
        do_txn(0, 1'b0, 64'h10, 64'h0, obs);
        check("err_mem_unchanged", obs, 64'h0123_4567_89AB_CDEF);
        do_txn(0, 1'b0, 64'h400, 64'h0, obs);
        check("err_oor_rdata", obs, 64'd0);
        do_txn(0, 1'b0, 64'h8000_0000_0000_0010, 64'h0, obs);
        do_txn(0, 1'b1, 64'h3F8, 64'h0BAD_C0DE_600D_F00D, obs);
        do_txn(0, 1'b0, 64'h3F8, 64'h0, obs);
        check("top_dword", obs, 64'h0BAD_C0DE_600D_F00D);

        // Reset while in WAIT: response dropped, store kept.
        push_exp(1'b1, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA);
        void'(exp_q.pop_back());
        send_req(0, 1'b1, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        check("midop_in_wait", 64'(dbg[0]), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("midop_no_valid", 64'(vld[0]), 64'd0);
            tick();
        end
        check("midop_ready", 64'(rr[0]), 64'd1);
        do_txn(0, 1'b0, 64'h20, 64'h0, obs);
        check("midop_store_kept", obs, 64'hAAAA_AAAA_AAAA_AAAA);

        // Random traffic with random response backpressure.
        for (int n = 0; n < 12; n++) begin
            a = 64'($urandom_range(0, 62)) << 3;
            if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(1, 7));
            w = 1'($urandom_range(0, 1));
            if (!w && !model.exists(a) && a[2:0] == 3'd0) w = 1'b1;
            d = {$urandom, $urandom};
            push_exp(w, a, d);
            send_req(0, w, a, d);
            finish_txn(0, $urandom_range(0, 3), obs);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
